// File: rtl/types_pkg.sv
// Shared types and defaults for the command-path blocks.
package types_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SPI_IDLE_BYTE = 8'h00;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead byte FIFO with valid/ready on both sides and a level output.
module byte_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  byte_t                  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output byte_t                  out_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           push;
    logic           pop;

    assign out_valid = (count_reg != '0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign in_ready  = (count_reg != FULL_COUNT) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr_reg] : '0;
    assign level     = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_bridge.sv
// Mode-0 SPI slave bridging host bytes into the pipeline command stream and
// returning response bytes on MISO; SPI pins are oversampled by clk.
module spi_cmd_bridge
    import types_pkg::*;
#(
    parameter int    FIFO_DEPTH  = 16,
    parameter byte_t IDLE_BYTE   = SPI_IDLE_BYTE,
    parameter int    SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        spi_sclk,
    input  logic                        spi_cs_n,
    input  logic                        spi_mosi,
    output logic                        spi_miso,
    output logic                        cmd_in_valid,
    input  logic                        cmd_in_ready,
    output byte_t                       cmd_in_data,
    input  logic                        cmd_out_valid,
    output logic                        cmd_out_ready,
    input  byte_t                       cmd_out_data,
    output logic                        rx_overflow,
    output logic [$clog2(FIFO_DEPTH):0] rx_level
);

    // Sync chain bit order is {sclk, cs_n, mosi}; cs_n resets deasserted.
    localparam logic [2:0] SYNC_RST = 3'b010;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [2:0] q;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= SYNC_RST;
                else     q <= {spi_sclk, spi_cs_n, spi_mosi};
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
                if (rst) q <= SYNC_RST;
                else     q <= g_sync[gi-1].q;
            end
        end
    end

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_d_reg, cs_d_reg;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign {sclk_s, cs_s, mosi_s} = g_sync[SYNC_STAGES-1].q;
    assign sclk_rise = sclk_s && !sclk_d_reg;
    assign sclk_fall = !sclk_s && sclk_d_reg;
    assign cs_fall   = !cs_s && cs_d_reg;
    assign cs_rise   = cs_s && !cs_d_reg;

    spi_state_e state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    byte_t      rx_shift_reg, rx_shift_next;
    byte_t      tx_shift_reg, tx_shift_next;
    logic       miso_reg;
    logic       overflow_reg;
    logic       load_tx;
    logic       push;
    logic       fifo_in_ready;

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_shift_next = rx_shift_reg;
        tx_shift_next = tx_shift_reg;
        load_tx       = 1'b0;
        push          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next   = ST_ACTIVE;
                    bit_cnt_next = '0;
                    load_tx      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Deselect wins over a coincident clock edge; the partial byte is dropped.
                if (cs_rise) begin
                    state_next    = ST_IDLE;
                    bit_cnt_next  = '0;
                    rx_shift_next = '0;
                end else if (sclk_rise) begin
                    rx_shift_next = {rx_shift_reg[6:0], mosi_s};
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    push          = (bit_cnt_reg == 3'd7);
                end else if (sclk_fall) begin
                    if (bit_cnt_reg == 3'd0) load_tx = 1'b1;
                    else                     tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (load_tx) begin
            tx_shift_next = cmd_out_valid ? cmd_out_data : IDLE_BYTE;
        end
    end

    assign cmd_out_ready = load_tx && cmd_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d_reg   <= 1'b0;
            cs_d_reg     <= 1'b1;
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
            tx_shift_reg <= '0;
            miso_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            sclk_d_reg   <= sclk_s;
            cs_d_reg     <= cs_s;
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_shift_reg <= rx_shift_next;
            tx_shift_reg <= tx_shift_next;
            miso_reg     <= (state_next == ST_ACTIVE) && tx_shift_next[7];
            if (push && !fifo_in_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign spi_miso    = miso_reg;
    assign rx_overflow = overflow_reg;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (push),
        .in_ready (fifo_in_ready),
        .in_data  (rx_shift_next),
        .out_valid(cmd_in_valid),
        .out_ready(cmd_in_ready),
        .out_data (cmd_in_data),
        .level    (rx_level)
    );

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Scoreboard bench for spi_cmd_bridge: SPI host model drives frames, a monitor checks cmd_in bytes.
module tb_spi_cmd_bridge;
    import types_pkg::*;

    localparam int DEPTH = 16;
    localparam int HALF  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        cmd_in_valid;
    logic        cmd_in_ready = 1'b0;
    byte_t       cmd_in_data;
    logic        cmd_out_valid = 1'b0;
    logic        cmd_out_ready;
    byte_t       cmd_out_data = 8'h00;
    logic        rx_overflow;
    logic [$clog2(DEPTH):0] rx_level;

    byte_t exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    ready_pulses = 0;
    logic  prev_ready = 1'b0;

    spi_cmd_bridge #(
        .FIFO_DEPTH (DEPTH),
        .IDLE_BYTE  (8'h00),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .cmd_in_data  (cmd_in_data),
        .cmd_out_valid(cmd_out_valid),
        .cmd_out_ready(cmd_out_ready),
        .cmd_out_data (cmd_out_data),
        .rx_overflow  (rx_overflow),
        .rx_level     (rx_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every cmd_in handshake pops the next expected byte.
    always @(negedge clk) begin
        if (!rst && cmd_in_valid && cmd_in_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_byte: got 0x%0h, expected none", cmd_in_data);
            end else begin
                check("cmd_in_data", int'(cmd_in_data), int'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (cmd_out_ready) ready_pulses++;
        if (cmd_out_ready && prev_ready) check("ready_consecutive", 1, 0);
        prev_ready = cmd_out_ready;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_cyc(HALF);
        m = spi_miso;
        spi_sclk = 1'b1;
        wait_cyc(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input byte_t tx, output byte_t rx);
        byte_t r;
        logic  m;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            r[i] = m;
        end
        rx = r;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_cyc(8);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        spi_cs_n = 1'b1;
        wait_cyc(8);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        cmd_in_ready = 1'b1;
        while ((exp_q.size() != 0 || cmd_in_valid) && t < 300) begin
            wait_cyc(1);
            t++;
        end
        check({name, "_drain_done"}, int'(t < 300), 1);
        wait_cyc(2);
        check({name, "_level_empty"}, int'(rx_level), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        byte_t r0, r1;
        logic  m, got;

        // Reset values
        wait_cyc(3);
        check("rst_miso", int'(spi_miso), 0);
        check("rst_in_valid", int'(cmd_in_valid), 0);
        check("rst_in_data", int'(cmd_in_data), 0);
        check("rst_out_ready", int'(cmd_out_ready), 0);
        check("rst_overflow", int'(rx_overflow), 0);
        check("rst_level", int'(rx_level), 0);
        rst = 1'b0;
        wait_cyc(3);

        // Reset in the middle of a frame with a byte stored and MISO high
        cmd_out_valid = 1'b1;
        cmd_out_data  = 8'hFF;
        cs_low();
        spi_byte(8'h77, r0);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
        check("pre_rst_level", int'(rx_level), 1);
        check("pre_rst_miso", int'(spi_miso), 1);
        rst = 1'b1;
        #1;
        check("arst_miso", int'(spi_miso), 0);
        check("arst_in_valid", int'(cmd_in_valid), 0);
        check("arst_in_data", int'(cmd_in_data), 0);
        check("arst_out_ready", int'(cmd_out_ready), 0);
        check("arst_level", int'(rx_level), 0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        cmd_out_valid = 1'b0;
        exp_q.delete();
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(4);
        cs_low();
        spi_byte(8'h81, r0);
        cs_high();
        check("post_rst_level", int'(rx_level), 1);
        check("post_rst_data", int'(cmd_in_data), 8'h81);
        exp_q.push_back(8'h81);
        drain("post_rst");

        // Two bytes in one frame with the consumer ready
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        cs_low();
        spi_byte(8'hA5, r0);
        spi_byte(8'h3C, r0);
        cs_high();
        drain("two_bytes");
        check("two_bytes_overflow", int'(rx_overflow), 0);

        // Response byte on MISO, then idle byte
        ready_pulses  = 0;
        cmd_out_data  = 8'h5A;
        cmd_out_valid = 1'b1;
        spi_cs_n = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            wait_cyc(1);
            if (cmd_out_ready) begin
                got = 1'b1;
                wait_cyc(1);
                cmd_out_valid = 1'b0;
            end
        end
        check("out_ready_seen", int'(got), 1);
        wait_cyc(6);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r1);
        cs_high();
        check("miso_byte0", int'(r0), 8'h5A);
        check("miso_byte1", int'(r1), 8'h00);
        check("out_ready_pulses", ready_pulses, 1);
        drain("miso_frame");

        // Overflow: 17 bytes into a 16-deep FIFO
        cmd_in_ready = 1'b0;
        cs_low();
        for (int i = 1; i <= 17; i++) begin
            spi_byte(byte_t'(8'h10 + i), r0);
            if (i <= DEPTH) exp_q.push_back(byte_t'(8'h10 + i));
        end
        cs_high();
        check("ovf_level", int'(rx_level), DEPTH);
        check("ovf_flag", int'(rx_overflow), 1);
        drain("ovf");
        check("ovf_sticky", int'(rx_overflow), 1);

        // Aborted partial byte, then a clean frame
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        cs_high();
        check("partial_no_push", int'(rx_level), 0);
        exp_q.push_back(8'h42);
        cs_low();
        spi_byte(8'h42, r0);
        cs_high();
        drain("after_partial");

        // Clear the sticky flag
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(3);
        check("rst2_overflow", int'(rx_overflow), 0);

        // Full FIFO with a pop in the same cycle as the 8th-bit push
        cmd_in_ready = 1'b0;
        cs_low();
        for (int i = 1; i <= DEPTH; i++) begin
            spi_byte(byte_t'(8'h20 + i), r0);
            exp_q.push_back(byte_t'(8'h20 + i));
        end
        for (int i = 7; i >= 1; i--) spi_bit(r0[0] | (8'hE7 >> i) & 1'b1, m);
        exp_q.push_back(8'hE7);
        spi_mosi = 1'b1;
        wait_cyc(HALF);
        spi_sclk = 1'b1;
        wait_cyc(2);
        cmd_in_ready = 1'b1;
        wait_cyc(1);
        cmd_in_ready = 1'b0;
        wait_cyc(HALF - 3);
        spi_sclk = 1'b0;
        cs_high();
        check("full_pop_level", int'(rx_level), DEPTH);
        check("full_pop_overflow", int'(rx_overflow), 0);
        drain("full_pop");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_bridge.md
Name: spi_cmd_bridge

Overview:
SPI slave (mode 0, MSB first) that turns the host's SPI link into the byte-stream command interface consumed by PipelineHead (cmd_in_*), and returns PipelineHead's response bytes (cmd_out_*) on MISO. It sits directly upstream of the pipeline head, between the FPGA SPI pins and the command parser. SPI signals are asynchronous to clk and are oversampled; clk must be at least 4x the SCLK frequency.

Parameters:
FIFO_DEPTH, 16, RX byte FIFO entries; power of 2, at least 2.
IDLE_BYTE, 8'h00, byte shifted out on MISO when no response byte is available.
SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, cs_n and mosi; at least 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
spi_sclk  in  1  SPI clock (idle low).
spi_cs_n  in  1  SPI chip select, active low.
spi_mosi  in  1  host-to-FPGA data.
spi_miso  out  1  FPGA-to-host data.
cmd_in_valid  out  1  received byte available (to PipelineHead cmd_in_valid).
cmd_in_ready  in  1  consumer accepts byte.
cmd_in_data  out  8  received byte (byte_t).
cmd_out_valid  in  1  response byte available (from PipelineHead cmd_out_valid).
cmd_out_ready  out  1  single-cycle pulse: response byte taken.
cmd_out_data  in  8  response byte (byte_t).
rx_overflow  out  1  sticky; a received byte was dropped because the FIFO was full.
rx_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): all outputs are 0. FIFO is empty, bit_cnt=0, state=IDLE, and both shift registers are 0.
- Input conditioning: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detect is performed on the synchronized sclk and cs_n against a one-cycle-delayed copy. mosi is sampled from its synchronized value in the same cycle the sclk rise is detected.
- FSM:
  - IDLE -> ACTIVE on a synchronized cs_n fall. In that cycle: bit_cnt=0, and tx_shift is loaded with cmd_out_data if cmd_out_valid (cmd_out_ready=1 for exactly that cycle), else with IDLE_BYTE.
  - ACTIVE -> IDLE on a synchronized cs_n rise. The partial RX byte is discarded and bit_cnt=0. A consumed TX byte that was not fully shifted is lost; no retry.
  - sclk edges are ignored in IDLE.
- Sclk rise (ACTIVE):
  - rx_shift={rx_shift[6:0],mosi_s}; bit_cnt++ (3-bit, wraps 7->0).
  - When bit_cnt was 7: push {rx_shift[6:0],mosi_s} into the FIFO in the same cycle.
- Sclk fall (ACTIVE):
  - If bit_cnt==0 (a byte boundary was just crossed): reload tx_shift exactly as on cs_n fall, including the cmd_out_ready pulse.
  - Otherwise: tx_shift<<=1.
- spi_miso=tx_shift[7] while ACTIVE, 0 while IDLE (registered; no tristate in this block).
- Latency: a byte is visible on cmd_in_valid within SYNC_STAGES+2 clk cycles after the pin-level 8th sclk rise.
- FIFO behaviour:
  - Show-ahead: cmd_in_valid = not empty; cmd_in_data = head entry. A pop occurs on cmd_in_valid & cmd_in_ready.
  - Push when full: if a pop happens in the same cycle, the push is accepted and rx_level is unchanged. Otherwise the byte is dropped and rx_overflow is set; it clears only on rst.
  - Push and pop in the same cycle on an empty FIFO: the byte is stored; no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- cmd_out_ready is never high in IDLE except in the cs_n-fall cycle, and is never high for two consecutive cycles.

Decomposition:
- byte_t comes from types_pkg.
- Add to the shared package: SPI_IDLE_BYTE, the default for IDLE_BYTE.
- Sub-module byte_fifo(DEPTH): synchronous show-ahead FIFO with valid/ready on both sides and a level output. It is reusable for the response path later.
- Synchronizers and edge detect stay inline.

Test Plan:
- Reset during an active frame (cs_n low, 4 bits shifted): all outputs go to 0 immediately. After release, a new frame sending 0x81 -> cmd_in_data=0x81, rx_level=1.
- One frame sending 0xA5 then 0x3C, cmd_in_ready=1 -> two cmd_in_valid handshakes with 0xA5 then 0x3C, in order; rx_overflow=0.
- cmd_out_valid=1, cmd_out_data=0x5A before cs_n fall, then cmd_out_valid=0, 16-bit frame -> MISO reads 0x5A then 0x00; exactly one cmd_out_ready pulse.
- cmd_in_ready=0, 17 bytes sent with FIFO_DEPTH=16 -> rx_level=16, rx_overflow=1. Then cmd_in_ready=1 drains bytes 1-16 intact; byte 17 is absent.
- cs_n raised after 5 bits of 0xFF -> no push. The next frame with 0x42 -> exactly one byte 0x42.
- FIFO full and cmd_in_ready=1 in the same cycle as an 8th-bit push -> rx_level stays 16, no overflow, the new byte appears last.
